// File: rtl/mm_pkg.sv
// ---------------------------------------------------------------------------
// mm_pkg
// Shared definitions for the MXU operand-buffer tile sequencer.
//   - Default widths for lengths, byte addresses and tile counts.
//   - FSM state encoding used by mm_buff_tile_seq.
//   - Buffer ram_type codes, reused as the channel index inside the
//     address generator so channel 1 is always the iram and channel 0
//     is always the wram.
//   - Small helper that decodes which states drive ctrl_vld to the buffers.
// ---------------------------------------------------------------------------
package mm_pkg;

    localparam int MM_ADDR_W = 12;
    localparam int MM_LEN_W  = 4;
    localparam int MM_TILE_W = 4;

    // Number of operand buffers driven by the sequencer (iram + wram).
    localparam int NUM_RAMS = 2;

    localparam logic [0:0] RAM_TYPE_IRAM = 1'b1;
    localparam logic [0:0] RAM_TYPE_WRAM = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_RUN   = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // The buffers count only while ctrl_vld is high: START and RUN.
    // GAP deliberately drops vld for one cycle so the buffer counters
    // freeze while the new start addresses are produced.
    function automatic logic is_vld_state(input state_t s);
        return (s == ST_START) || (s == ST_RUN);
    endfunction

endpackage : mm_pkg

// File: rtl/mm_tile_addr_gen.sv
// ---------------------------------------------------------------------------
// mm_tile_addr_gen
// Two independent base/stride accumulators, one per operand buffer.
// Channel index follows the buffer ram_type code (1 = iram, 0 = wram).
//
// Ports:
//   clk     in   clock
//   rst_n   in   asynchronous active-low reset
//   clr     in   synchronous clear of addresses and strides (flush)
//   load    in   load base into the address and capture the stride
//   inc     in   add the captured stride to the address
//   base    in   [NUM_RAMS][ADDR_W] start byte address of tile 0
//   stride  in   [NUM_RAMS][ADDR_W] per-tile address increment
//   addr    out  [NUM_RAMS][ADDR_W] current tile start byte address
//
// Priority: clr > load > inc. Addition wraps modulo 2^ADDR_W.
// ---------------------------------------------------------------------------
module mm_tile_addr_gen
    import mm_pkg::*;
#(
    parameter int ADDR_W = MM_ADDR_W
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clr,
    input  logic                             load,
    input  logic                             inc,
    input  logic [NUM_RAMS-1:0][ADDR_W-1:0]  base,
    input  logic [NUM_RAMS-1:0][ADDR_W-1:0]  stride,
    output logic [NUM_RAMS-1:0][ADDR_W-1:0]  addr
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RAMS; gi++) begin : g_chan
            logic [ADDR_W-1:0] addr_reg;
            logic [ADDR_W-1:0] stride_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    addr_reg   <= '0;
                    stride_reg <= '0;
                end else if (clr) begin
                    addr_reg   <= '0;
                    stride_reg <= '0;
                end else if (load) begin
                    addr_reg   <= base[gi];
                    stride_reg <= stride[gi];
                end else if (inc) begin
                    // Carry out is dropped on purpose: addresses wrap silently.
                    addr_reg   <= addr_reg + stride_reg;
                end
            end

            assign addr[gi] = addr_reg;
        end
    endgenerate

endmodule : mm_tile_addr_gen

// File: rtl/mm_buff_tile_seq.sv
// ---------------------------------------------------------------------------
// mm_buff_tile_seq
// Sequencer for a pair of MXU operand buffers (one iram, one wram).
// A matmul command is split along K into (cmd_tile_num+1) tiles. For each
// tile the sequencer pulses buf_start, holds buf_vld while the buffers
// stream, waits until both buffers have signalled their end flag, then
// spends one GAP cycle with buf_vld low while the start addresses advance
// by their strides.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_vld / cmd_rdy          command handshake from LSU decode
//   cmd_row_len, cmd_col_len   lengths-1, forwarded to both buffers
//   cmd_tile_num               number of K tiles - 1
//   cmd_iram_base/_stride      iram tile-0 address and per-tile increment
//   cmd_wram_base/_stride      wram tile-0 address and per-tile increment
//   abort                      synchronous flush back to IDLE
//   buf_start, buf_vld         start pulse / ctrl_vld to both buffers
//   buf_row_len, buf_col_len   lengths to both buffers
//   buf_iram_addr/wram_addr    per-buffer start_addr
//   iram_end, wram_end         buffer mxu_end flags
//   mxu_tile_first/last        accumulator control, valid with buf_vld
//   seq_busy, seq_done         status, done is a one-cycle pulse
//
// All outputs except cmd_rdy are registered; they are computed from the
// next-state values so they line up with the state register.
// ---------------------------------------------------------------------------
module mm_buff_tile_seq
    import mm_pkg::*;
#(
    parameter int ADDR_W = MM_ADDR_W,
    parameter int LEN_W  = MM_LEN_W,
    parameter int TILE_W = MM_TILE_W
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              cmd_vld,
    output logic              cmd_rdy,
    input  logic [LEN_W-1:0]  cmd_row_len,
    input  logic [LEN_W-1:0]  cmd_col_len,
    input  logic [TILE_W-1:0] cmd_tile_num,
    input  logic [ADDR_W-1:0] cmd_iram_base,
    input  logic [ADDR_W-1:0] cmd_wram_base,
    input  logic [ADDR_W-1:0] cmd_iram_stride,
    input  logic [ADDR_W-1:0] cmd_wram_stride,
    input  logic              abort,

    output logic              buf_start,
    output logic              buf_vld,
    output logic [LEN_W-1:0]  buf_row_len,
    output logic [LEN_W-1:0]  buf_col_len,
    output logic [ADDR_W-1:0] buf_iram_addr,
    output logic [ADDR_W-1:0] buf_wram_addr,
    input  logic              iram_end,
    input  logic              wram_end,

    output logic              mxu_tile_first,
    output logic              mxu_tile_last,
    output logic              seq_busy,
    output logic              seq_done
);

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    state_t             state_reg;
    state_t             state_next;
    logic [TILE_W-1:0]  tile_idx_reg;
    logic [TILE_W-1:0]  tile_idx_next;
    logic [TILE_W-1:0]  tile_num_reg;
    logic [TILE_W-1:0]  tile_num_next;
    logic [LEN_W-1:0]   row_len_reg;
    logic [LEN_W-1:0]   col_len_reg;
    logic               end_i_reg;
    logic               end_w_reg;

    logic               buf_start_reg;
    logic               buf_vld_reg;
    logic               tile_first_reg;
    logic               tile_last_reg;
    logic               busy_reg;
    logic               done_reg;

    logic               capture;
    logic               advance;
    logic               both_end;
    logic               vld_next;

    // The end of a tile counts the flag arriving this cycle as well as any
    // flag latched earlier, so simultaneous and skewed ends both work.
    assign both_end = (end_i_reg | iram_end) & (end_w_reg | wram_end);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        tile_idx_next = tile_idx_reg;
        tile_num_next = tile_num_reg;
        capture       = 1'b0;
        advance       = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                if (cmd_vld) begin
                    capture       = 1'b1;
                    state_next    = ST_START;
                    tile_idx_next = '0;
                    tile_num_next = cmd_tile_num;
                end
            end
            ST_START: begin
                state_next = ST_RUN;
            end
            ST_RUN: begin
                if (both_end) begin
                    state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (tile_idx_reg == tile_num_reg) begin
                    state_next = ST_DONE;
                end else begin
                    advance       = 1'b1;
                    tile_idx_next = tile_idx_reg + TILE_W'(1);
                    state_next    = ST_START;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Flush overrides everything, including a command offered in IDLE.
        if (abort) begin
            state_next    = ST_IDLE;
            tile_idx_next = '0;
            capture       = 1'b0;
            advance       = 1'b0;
        end
    end

    assign vld_next = is_vld_state(state_next);

    // -----------------------------------------------------------------------
    // FSM, end latches and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            tile_idx_reg   <= '0;
            tile_num_reg   <= '0;
            row_len_reg    <= '0;
            col_len_reg    <= '0;
            end_i_reg      <= 1'b0;
            end_w_reg      <= 1'b0;
            buf_start_reg  <= 1'b0;
            buf_vld_reg    <= 1'b0;
            tile_first_reg <= 1'b0;
            tile_last_reg  <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg    <= state_next;
            tile_idx_reg <= tile_idx_next;
            tile_num_reg <= tile_num_next;

            if (capture) begin
                row_len_reg <= cmd_row_len;
                col_len_reg <= cmd_col_len;
            end

            // End flags are collected only while the buffers are running
            // (START and RUN); GAP wipes them for the next tile and flags
            // seen in IDLE/DONE are simply not recorded.
            if (abort || (state_reg == ST_GAP)) begin
                end_i_reg <= 1'b0;
                end_w_reg <= 1'b0;
            end else if ((state_reg == ST_START) || (state_reg == ST_RUN)) begin
                end_i_reg <= end_i_reg | iram_end;
                end_w_reg <= end_w_reg | wram_end;
            end

            buf_start_reg  <= (state_next == ST_START);
            buf_vld_reg    <= vld_next;
            tile_first_reg <= vld_next && (tile_idx_next == '0);
            tile_last_reg  <= vld_next && (tile_idx_next == tile_num_next);
            busy_reg       <= (state_next != ST_IDLE);
            done_reg       <= (state_next == ST_DONE);
        end
    end

    // -----------------------------------------------------------------------
    // Address generation
    // -----------------------------------------------------------------------
    logic [NUM_RAMS-1:0][ADDR_W-1:0] base_vec;
    logic [NUM_RAMS-1:0][ADDR_W-1:0] stride_vec;
    logic [NUM_RAMS-1:0][ADDR_W-1:0] addr_vec;

    assign base_vec[RAM_TYPE_IRAM]   = cmd_iram_base;
    assign base_vec[RAM_TYPE_WRAM]   = cmd_wram_base;
    assign stride_vec[RAM_TYPE_IRAM] = cmd_iram_stride;
    assign stride_vec[RAM_TYPE_WRAM] = cmd_wram_stride;

    mm_tile_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (abort),
        .load   (capture),
        .inc    (advance),
        .base   (base_vec),
        .stride (stride_vec),
        .addr   (addr_vec)
    );

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign cmd_rdy        = (state_reg == ST_IDLE);
    assign buf_start      = buf_start_reg;
    assign buf_vld        = buf_vld_reg;
    assign buf_row_len    = row_len_reg;
    assign buf_col_len    = col_len_reg;
    assign buf_iram_addr  = addr_vec[RAM_TYPE_IRAM];
    assign buf_wram_addr  = addr_vec[RAM_TYPE_WRAM];
    assign mxu_tile_first = tile_first_reg;
    assign mxu_tile_last  = tile_last_reg;
    assign seq_busy       = busy_reg;
    assign seq_done       = done_reg;

endmodule : mm_buff_tile_seq

// File: tb/tb_mm_buff_tile_seq.sv
// ---------------------------------------------------------------------------
// tb_mm_buff_tile_seq
// Directed bench for the tile sequencer. Each task drives one scenario and
// compares the outputs against hand-computed values. Inputs change 1 ns
// after the rising edge; outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_mm_buff_tile_seq;

    localparam int ADDR_W = 12;
    localparam int LEN_W  = 4;
    localparam int TILE_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_vld = 1'b0;
    logic              cmd_rdy;
    logic [LEN_W-1:0]  cmd_row_len = '0;
    logic [LEN_W-1:0]  cmd_col_len = '0;
    logic [TILE_W-1:0] cmd_tile_num = '0;
    logic [ADDR_W-1:0] cmd_iram_base = '0;
    logic [ADDR_W-1:0] cmd_wram_base = '0;
    logic [ADDR_W-1:0] cmd_iram_stride = '0;
    logic [ADDR_W-1:0] cmd_wram_stride = '0;
    logic              abort = 1'b0;
    logic              buf_start;
    logic              buf_vld;
    logic [LEN_W-1:0]  buf_row_len;
    logic [LEN_W-1:0]  buf_col_len;
    logic [ADDR_W-1:0] buf_iram_addr;
    logic [ADDR_W-1:0] buf_wram_addr;
    logic              iram_end = 1'b0;
    logic              wram_end = 1'b0;
    logic              mxu_tile_first;
    logic              mxu_tile_last;
    logic              seq_busy;
    logic              seq_done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mm_buff_tile_seq #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W),
        .TILE_W (TILE_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cmd_vld         (cmd_vld),
        .cmd_rdy         (cmd_rdy),
        .cmd_row_len     (cmd_row_len),
        .cmd_col_len     (cmd_col_len),
        .cmd_tile_num    (cmd_tile_num),
        .cmd_iram_base   (cmd_iram_base),
        .cmd_wram_base   (cmd_wram_base),
        .cmd_iram_stride (cmd_iram_stride),
        .cmd_wram_stride (cmd_wram_stride),
        .abort           (abort),
        .buf_start       (buf_start),
        .buf_vld         (buf_vld),
        .buf_row_len     (buf_row_len),
        .buf_col_len     (buf_col_len),
        .buf_iram_addr   (buf_iram_addr),
        .buf_wram_addr   (buf_wram_addr),
        .iram_end        (iram_end),
        .wram_end        (wram_end),
        .mxu_tile_first  (mxu_tile_first),
        .mxu_tile_last   (mxu_tile_last),
        .seq_busy        (seq_busy),
        .seq_done        (seq_done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for cmd_rdy, offers one command and moves to START.
    // With keep=1 cmd_vld stays high after the capture edge.
    task automatic send_cmd(input logic [3:0] row, input logic [3:0] col,
                            input logic [3:0] tiles,
                            input logic [11:0] ib, input logic [11:0] wb,
                            input logic [11:0] is, input logic [11:0] ws,
                            input bit keep);
        int n = 0;
        while (cmd_rdy !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (cmd_rdy !== 1'b1) begin
            errors++;
            $display("FAIL cmd_rdy_wait: cmd_rdy=%b required 1 within 20 cycles", cmd_rdy);
        end
        cmd_row_len     = row;
        cmd_col_len     = col;
        cmd_tile_num    = tiles;
        cmd_iram_base   = ib;
        cmd_wram_base   = wb;
        cmd_iram_stride = is;
        cmd_wram_stride = ws;
        cmd_vld         = 1'b1;
        tick();
        if (!keep) cmd_vld = 1'b0;
        checks++;
        if ({buf_row_len, buf_col_len} !== {row, col}) begin
            errors++;
            $display("FAIL cmd_lengths: row/col=%h/%h required %h/%h",
                     buf_row_len, buf_col_len, row, col);
        end
        $display("cmd   row=%0d col=%0d tiles=%0d ib=%h wb=%h is=%h ws=%h",
                 row, col, tiles, ib, wb, is, ws);
    endtask

    // Entered in the START cycle of a tile. di/dw give the RUN cycle (1-based)
    // in which iram_end/wram_end pulse; 0 means the pulse is in START.
    // gap_noise drives both end flags high during the GAP cycle.
    task automatic run_tile(input logic [11:0] ia, input logic [11:0] wa,
                            input bit first, input bit last,
                            input int di, input int dw, input bit gap_noise);
        int mx;
        mx = (di > dw) ? di : dw;
        checks++;
        if ({buf_start, buf_vld, seq_busy, cmd_rdy} !== 4'b1110) begin
            errors++;
            $display("FAIL start_ctrl: start/vld/busy/rdy=%b required 1110",
                     {buf_start, buf_vld, seq_busy, cmd_rdy});
        end
        checks++;
        if ({buf_iram_addr, buf_wram_addr} !== {ia, wa}) begin
            errors++;
            $display("FAIL start_addr: iram/wram=%h/%h required %h/%h",
                     buf_iram_addr, buf_wram_addr, ia, wa);
        end
        checks++;
        if ({mxu_tile_first, mxu_tile_last} !== {first, last}) begin
            errors++;
            $display("FAIL start_first_last: first/last=%b%b required %b%b",
                     mxu_tile_first, mxu_tile_last, first, last);
        end
        iram_end = (di == 0);
        wram_end = (dw == 0);
        tick();
        for (int c = 1; c <= mx; c++) begin
            iram_end = (c == di);
            wram_end = (c == dw);
            checks++;
            if ({buf_start, buf_vld, mxu_tile_first, mxu_tile_last, seq_done} !==
                {1'b0, 1'b1, first, last, 1'b0}) begin
                errors++;
                $display("FAIL run_cycle%0d: start/vld/first/last/done=%b required %b",
                         c, {buf_start, buf_vld, mxu_tile_first, mxu_tile_last, seq_done},
                         {1'b0, 1'b1, first, last, 1'b0});
            end
            tick();
        end
        iram_end = gap_noise;
        wram_end = gap_noise;
        checks++;
        if ({buf_start, buf_vld, mxu_tile_first, mxu_tile_last, seq_busy, seq_done} !== 6'b000010) begin
            errors++;
            $display("FAIL gap: start/vld/first/last/busy/done=%b required 000010",
                     {buf_start, buf_vld, mxu_tile_first, mxu_tile_last, seq_busy, seq_done});
        end
        tick();
        iram_end = 1'b0;
        wram_end = 1'b0;
        $display("tile  iram=%h wram=%h first=%0d last=%0d end_i@%0d end_w@%0d",
                 ia, wa, first, last, di, dw);
    endtask

    // Entered in the DONE cycle; leaves in IDLE.
    task automatic expect_done;
        checks++;
        if ({seq_done, buf_vld, seq_busy, cmd_rdy} !== 4'b1010) begin
            errors++;
            $display("FAIL done_pulse: done/vld/busy/rdy=%b required 1010",
                     {seq_done, buf_vld, seq_busy, cmd_rdy});
        end
        tick();
        checks++;
        if ({seq_done, seq_busy, cmd_rdy} !== 3'b001) begin
            errors++;
            $display("FAIL after_done: done/busy/rdy=%b required 001",
                     {seq_done, seq_busy, cmd_rdy});
        end
        $display("done  command complete");
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        checks++;
        if ({cmd_rdy, buf_start, buf_vld, mxu_tile_first, mxu_tile_last, seq_busy, seq_done} !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_ctrl: rdy/start/vld/first/last/busy/done=%b required 1000000",
                     {cmd_rdy, buf_start, buf_vld, mxu_tile_first, mxu_tile_last, seq_busy, seq_done});
        end
        checks++;
        if ({buf_iram_addr, buf_wram_addr, buf_row_len, buf_col_len} !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: addr/len=%h required 0",
                     {buf_iram_addr, buf_wram_addr, buf_row_len, buf_col_len});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        $display("reset released");
    endtask

    task automatic test_single_tile;
        send_cmd(4'd3, 4'd3, 4'd0, 12'h040, 12'h080, 12'h010, 12'h010, 1'b0);
        run_tile(12'h040, 12'h080, 1'b1, 1'b1, 7, 7, 1'b0);
        expect_done();
    endtask

    task automatic test_three_tiles;
        send_cmd(4'd2, 4'd1, 4'd2, 12'h100, 12'h200, 12'h010, 12'h020, 1'b0);
        // Ends in GAP must not leak into the next tile.
        run_tile(12'h100, 12'h200, 1'b1, 1'b0, 4, 4, 1'b1);
        // iram_end during START is kept; wram_end arrives later.
        run_tile(12'h110, 12'h220, 1'b0, 1'b0, 0, 3, 1'b1);
        run_tile(12'h120, 12'h240, 1'b0, 1'b1, 2, 2, 1'b0);
        expect_done();
    endtask

    task automatic test_skewed;
        send_cmd(4'd1, 4'd2, 4'd0, 12'h300, 12'h310, 12'h000, 12'h000, 1'b0);
        run_tile(12'h300, 12'h310, 1'b1, 1'b1, 2, 5, 1'b0);
        expect_done();
        send_cmd(4'd1, 4'd2, 4'd0, 12'h320, 12'h330, 12'h000, 12'h000, 1'b0);
        run_tile(12'h320, 12'h330, 1'b1, 1'b1, 6, 1, 1'b0);
        expect_done();
    endtask

    task automatic test_wrap;
        // wram stride 0: the same tile address repeats.
        send_cmd(4'd0, 4'd0, 4'd1, 12'hFF0, 12'h123, 12'h020, 12'h000, 1'b0);
        run_tile(12'hFF0, 12'h123, 1'b1, 1'b0, 1, 1, 1'b0);
        run_tile(12'h010, 12'h123, 1'b0, 1'b1, 1, 1, 1'b0);
        expect_done();
    endtask

    task automatic test_abort;
        send_cmd(4'd1, 4'd1, 4'd3, 12'h400, 12'h500, 12'h004, 12'h008, 1'b0);
        run_tile(12'h400, 12'h500, 1'b1, 1'b0, 3, 3, 1'b0);
        checks++;
        if ({buf_start, buf_iram_addr, buf_wram_addr} !== {1'b1, 12'h404, 12'h508}) begin
            errors++;
            $display("FAIL abort_tile1_start: start/iram/wram=%b/%h/%h required 1/404/508",
                     buf_start, buf_iram_addr, buf_wram_addr);
        end
        tick();
        iram_end = 1'b1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        iram_end = 1'b0;
        checks++;
        if ({buf_vld, buf_start, mxu_tile_first, mxu_tile_last, seq_busy, seq_done, cmd_rdy} !== 7'b0000001) begin
            errors++;
            $display("FAIL abort_flush: vld/start/first/last/busy/done/rdy=%b required 0000001",
                     {buf_vld, buf_start, mxu_tile_first, mxu_tile_last, seq_busy, seq_done, cmd_rdy});
        end
        tick();
        checks++;
        if ({seq_done, seq_busy} !== 2'b00) begin
            errors++;
            $display("FAIL abort_no_done: done/busy=%b required 00", {seq_done, seq_busy});
        end
        $display("abort during tile 1 of 4");
        // Fresh command restarts from tile 0 with its own base.
        send_cmd(4'd2, 4'd2, 4'd0, 12'h600, 12'h700, 12'h001, 12'h001, 1'b0);
        run_tile(12'h600, 12'h700, 1'b1, 1'b1, 5, 5, 1'b0);
        expect_done();
        // abort beats a simultaneous command in IDLE.
        cmd_vld = 1'b1;
        abort = 1'b1;
        tick();
        cmd_vld = 1'b0;
        abort = 1'b0;
        checks++;
        if ({buf_start, buf_vld, seq_busy, cmd_rdy} !== 4'b0001) begin
            errors++;
            $display("FAIL abort_vs_cmd: start/vld/busy/rdy=%b required 0001",
                     {buf_start, buf_vld, seq_busy, cmd_rdy});
        end
        $display("abort with cmd_vld in IDLE");
    endtask

    task automatic test_backpressure;
        send_cmd(4'd0, 4'd0, 4'd0, 12'h010, 12'h020, 12'h000, 12'h000, 1'b1);
        // Second command offered immediately and held while busy.
        cmd_row_len   = 4'd1;
        cmd_col_len   = 4'd1;
        cmd_iram_base = 12'h0A0;
        cmd_wram_base = 12'h0B0;
        run_tile(12'h010, 12'h020, 1'b1, 1'b1, 1, 1, 1'b0);
        expect_done();
        tick();
        cmd_vld = 1'b0;
        checks++;
        if ({buf_row_len, buf_col_len} !== 8'h11) begin
            errors++;
            $display("FAIL bp_second_len: row/col=%h/%h required 1/1", buf_row_len, buf_col_len);
        end
        run_tile(12'h0A0, 12'h0B0, 1'b1, 1'b1, 2, 2, 1'b0);
        expect_done();
        tick();
        checks++;
        if ({buf_start, buf_vld, seq_busy} !== 3'b000) begin
            errors++;
            $display("FAIL bp_single_capture: start/vld/busy=%b required 000",
                     {buf_start, buf_vld, seq_busy});
        end
        $display("backpressure second command captured once");
    endtask

    task automatic test_async_reset;
        send_cmd(4'd3, 4'd3, 4'd1, 12'h800, 12'h900, 12'h010, 12'h010, 1'b0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({buf_vld, buf_start, seq_busy, cmd_rdy, buf_iram_addr} !== {4'b0001, 12'h000}) begin
            errors++;
            $display("FAIL async_reset: vld/start/busy/rdy=%b iram=%h required 0001/000",
                     {buf_vld, buf_start, seq_busy, cmd_rdy}, buf_iram_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        $display("async reset mid-run");
    endtask

    initial begin
        test_reset();
        test_single_tile();
        test_three_tiles();
        test_skewed();
        test_wrap();
        test_abort();
        test_backpressure();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mm_buff_tile_seq
